// File: rtl/nclic_pkg.sv
// Shared types and default widths for the nested interrupt controller dispatch stage.
package nclic_pkg;

    localparam int unsigned NUM_IRQ     = 16;
    localparam int unsigned IDX_WIDTH   = $clog2(NUM_IRQ);
    localparam int unsigned PRIO_WIDTH  = 4;
    localparam int unsigned STACK_DEPTH = 8;

    typedef logic [IDX_WIDTH-1:0]  idx_t;
    typedef logic [PRIO_WIDTH-1:0] prio_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } dispatch_state_e;

endpackage

// File: rtl/prio_stack.sv
// LIFO of saved priority levels; a simultaneous push and pop replaces the top entry.
module prio_stack
    import nclic_pkg::*;
#(
    parameter int unsigned PrioWidth  = PRIO_WIDTH,
    parameter int unsigned StackDepth = STACK_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [PrioWidth-1:0] push_data,
    output logic [PrioWidth-1:0] top,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned CntW = $clog2(StackDepth + 1);
    localparam int unsigned PtrW = (StackDepth > 1) ? $clog2(StackDepth) : 1;

    logic [PrioWidth-1:0] mem [StackDepth];
    logic [CntW-1:0]      cnt;
    logic [CntW-1:0]      cnt_d;
    logic [PtrW-1:0]      top_ptr;
    logic [PtrW-1:0]      wr_ptr;
    logic                 pop_ok;
    logic                 push_ok;

    assign top_ptr = PtrW'(cnt - CntW'(1));
    assign top     = empty ? '0 : mem[top_ptr];

    // A pop on an empty stack is dropped; a push into a full stack only lands when paired with a pop.
    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        wr_ptr  = pop_ok ? top_ptr : PtrW'(cnt);
        cnt_d   = cnt;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt + CntW'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            cnt   <= cnt_d;
            full  <= (cnt_d == CntW'(StackDepth));
            empty <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/irq_dispatch.sv
// Dispatch stage: raises preempting requests, runs the take/ack handshake and tracks nesting.
// IRQ_DISPATCH_TAILCHAIN_EN: on a return in IDLE, compare the winner against the post-pop level.
module irq_dispatch
    import nclic_pkg::*;
#(
    parameter  int unsigned NumIrq     = NUM_IRQ,
    parameter  int unsigned PrioWidth  = PRIO_WIDTH,
    parameter  int unsigned StackDepth = STACK_DEPTH,
    localparam int unsigned IdxWidth   = $clog2(NumIrq)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 win_valid,
    input  logic [IdxWidth-1:0]  win_id,
    input  logic [PrioWidth-1:0] win_prio,
    output logic                 irq_req,
    output logic [IdxWidth-1:0]  irq_id,
    output logic [PrioWidth-1:0] irq_prio,
    input  logic                 irq_ack,
    input  logic                 irq_ret,
    output logic                 clear_valid,
    output logic [IdxWidth-1:0]  clear_id,
    output logic [PrioWidth-1:0] cur_prio,
    output logic                 stack_full,
    output logic                 ret_err
);

    dispatch_state_e      state;
    dispatch_state_e      state_d;
    logic [IdxWidth-1:0]  id_d;
    logic [PrioWidth-1:0] prio_d;
    logic [PrioWidth-1:0] cur_d;
    logic                 clr_v_d;
    logic [IdxWidth-1:0]  clr_id_d;
    logic                 err_d;
    logic                 push;
    logic                 pop;
    logic [PrioWidth-1:0] push_data;
    logic [PrioWidth-1:0] cmp_prio;
    logic                 blocked;
    logic [PrioWidth-1:0] stk_top;
    logic                 stk_empty;

    prio_stack #(
        .PrioWidth (PrioWidth),
        .StackDepth(StackDepth)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_data(push_data),
        .top      (stk_top),
        .full     (stack_full),
        .empty    (stk_empty)
    );

    // On return+ack the pop happens first, so the saved level is the popped one (stack unchanged).
    always_comb begin
        state_d   = state;
        id_d      = irq_id;
        prio_d    = irq_prio;
        cur_d     = cur_prio;
        clr_v_d   = 1'b0;
        clr_id_d  = clear_id;
        err_d     = ret_err;
        push      = 1'b0;
        pop       = irq_ret && !stk_empty;
        push_data = pop ? stk_top : cur_prio;
        cmp_prio  = cur_prio;
        blocked   = stack_full;
`ifdef IRQ_DISPATCH_TAILCHAIN_EN
        if (state == IDLE && pop) begin
            cmp_prio = stk_top;
            blocked  = 1'b0;
        end
`endif
        if (irq_ret && stk_empty) begin
            err_d = 1'b1;
        end
        if (pop) begin
            cur_d = stk_top;
        end
        case (state)
            IDLE: begin
                if (win_valid && (win_prio > cmp_prio) && !blocked) begin
                    state_d = REQ;
                    id_d    = win_id;
                    prio_d  = win_prio;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    push     = 1'b1;
                    cur_d    = irq_prio;
                    clr_v_d  = 1'b1;
                    clr_id_d = irq_id;
                    state_d  = IDLE;
                end else if (!win_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            irq_req     <= 1'b0;
            irq_id      <= '0;
            irq_prio    <= '0;
            clear_valid <= 1'b0;
            clear_id    <= '0;
            cur_prio    <= '0;
            ret_err     <= 1'b0;
        end else begin
            state       <= state_d;
            irq_req     <= (state_d == REQ);
            irq_id      <= id_d;
            irq_prio    <= prio_d;
            clear_valid <= clr_v_d;
            clear_id    <= clr_id_d;
            cur_prio    <= cur_d;
            ret_err     <= err_d;
        end
    end

endmodule

// File: tb/tb_irq_dispatch.sv
// Scoreboard bench for irq_dispatch: request/clear expectations are queued, a monitor checks them.
module tb_irq_dispatch;

    typedef struct {
        logic [3:0] id;
        logic [3:0] prio;
    } exp_req_t;

`ifdef IRQ_DISPATCH_TAILCHAIN_EN
    localparam logic TC = 1'b1;
`else
    localparam logic TC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       win_valid = 1'b0;
    logic [3:0] win_id = '0;
    logic [3:0] win_prio = '0;
    logic       irq_ack = 1'b0;
    logic       irq_ret = 1'b0;
    logic       irq_req;
    logic [3:0] irq_id;
    logic [3:0] irq_prio;
    logic       clear_valid;
    logic [3:0] clear_id;
    logic [3:0] cur_prio;
    logic       stack_full;
    logic       ret_err;

    logic       b_win_valid = 1'b0;
    logic [3:0] b_win_id = '0;
    logic [3:0] b_win_prio = '0;
    logic       b_ack = 1'b0;
    logic       b_ret = 1'b0;
    logic       b_irq_req;
    logic [3:0] b_irq_id;
    logic [3:0] b_irq_prio;
    logic       b_clear_valid;
    logic [3:0] b_clear_id;
    logic [3:0] b_cur_prio;
    logic       b_stack_full;
    logic       b_ret_err;

    int errors = 0;
    int checks = 0;
    exp_req_t   req_q[$];
    logic [3:0] clr_q[$];
    logic       req_prev = 1'b0;

    irq_dispatch dut (
        .clk        (clk),
        .reset      (reset),
        .win_valid  (win_valid),
        .win_id     (win_id),
        .win_prio   (win_prio),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_prio   (irq_prio),
        .irq_ack    (irq_ack),
        .irq_ret    (irq_ret),
        .clear_valid(clear_valid),
        .clear_id   (clear_id),
        .cur_prio   (cur_prio),
        .stack_full (stack_full),
        .ret_err    (ret_err)
    );

    irq_dispatch #(.StackDepth(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .win_valid  (b_win_valid),
        .win_id     (b_win_id),
        .win_prio   (b_win_prio),
        .irq_req    (b_irq_req),
        .irq_id     (b_irq_id),
        .irq_prio   (b_irq_prio),
        .irq_ack    (b_ack),
        .irq_ret    (b_ret),
        .clear_valid(b_clear_valid),
        .clear_id   (b_clear_id),
        .cur_prio   (b_cur_prio),
        .stack_full (b_stack_full),
        .ret_err    (b_ret_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: run time exceeded");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rising irq_req and every clear pulse must match the head of its queue.
    always @(negedge clk) begin
        if (reset) begin
            req_prev = 1'b0;
        end else begin
            if (irq_req && !req_prev) begin
                checks++;
                if (req_q.size() == 0) begin
                    errors++;
                    $display("FAIL req_unexpected: id=%0d prio=%0d with nothing expected", irq_id, irq_prio);
                end else begin
                    exp_req_t e;
                    e = req_q.pop_front();
                    if (irq_id !== e.id || irq_prio !== e.prio) begin
                        errors++;
                        $display("FAIL req_payload: got id=%0d prio=%0d expected id=%0d prio=%0d",
                                 irq_id, irq_prio, e.id, e.prio);
                    end
                end
            end
            req_prev = irq_req;
            if (clear_valid) begin
                checks++;
                if (clr_q.size() == 0) begin
                    errors++;
                    $display("FAIL clear_unexpected: clear_id=%0d with nothing expected", clear_id);
                end else begin
                    logic [3:0] c;
                    c = clr_q.pop_front();
                    if (clear_id !== c) begin
                        errors++;
                        $display("FAIL clear_id: got %0d expected %0d", clear_id, c);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        win_valid = 1'b0; irq_ack = 1'b0; irq_ret = 1'b0;
        b_win_valid = 1'b0; b_ack = 1'b0; b_ret = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic expect_req(input logic [3:0] id, input logic [3:0] prio);
        exp_req_t e;
        e.id = id;
        e.prio = prio;
        req_q.push_back(e);
    endtask

    // Raise, take and acknowledge one interrupt on the main instance.
    task automatic take(input logic [3:0] id, input logic [3:0] prio);
        win_valid = 1'b1; win_id = id; win_prio = prio;
        expect_req(id, prio);
        step();
        check("take_req", 8'(irq_req), 8'd1);
        irq_ack = 1'b1;
        clr_q.push_back(id);
        step();
        irq_ack = 1'b0; win_valid = 1'b0;
        check("take_cur_prio", 8'(cur_prio), 8'(prio));
    endtask

    task automatic ret_pulse();
        irq_ret = 1'b1;
        step();
        irq_ret = 1'b0;
    endtask

    task automatic take_b(input logic [3:0] id, input logic [3:0] prio);
        b_win_valid = 1'b1; b_win_id = id; b_win_prio = prio;
        step();
        check("b_take_req", 8'(b_irq_req), 8'd1);
        b_ack = 1'b1;
        step();
        b_ack = 1'b0; b_win_valid = 1'b0;
        check("b_take_cur_prio", 8'(b_cur_prio), 8'(prio));
    endtask

    initial begin
        apply_reset();
        check("rst_irq_req", 8'(irq_req), 8'd0);
        check("rst_cur_prio", 8'(cur_prio), 8'd0);
        check("rst_clear_valid", 8'(clear_valid), 8'd0);
        check("rst_stack_full", 8'(stack_full), 8'd0);
        check("rst_ret_err", 8'(ret_err), 8'd0);
        check("rst_irq_id", 8'(irq_id), 8'd0);

        // Basic take: request at +1, clear and level update at ack+1.
        win_valid = 1'b1; win_id = 4'd5; win_prio = 4'd3;
        expect_req(4'd5, 4'd3);
        step();
        check("basic_req", 8'(irq_req), 8'd1);
        irq_ack = 1'b1;
        clr_q.push_back(4'd5);
        step();
        irq_ack = 1'b0; win_valid = 1'b0;
        check("basic_clear_valid", 8'(clear_valid), 8'd1);
        check("basic_cur_prio", 8'(cur_prio), 8'd3);
        check("basic_req_drop", 8'(irq_req), 8'd0);
        step();
        check("basic_clear_pulse", 8'(clear_valid), 8'd0);

        // Equal priority never preempts; one level higher does.
        win_valid = 1'b1; win_id = 4'd2; win_prio = 4'd3;
        step();
        step();
        check("equal_no_req", 8'(irq_req), 8'd0);
        win_id = 4'd4; win_prio = 4'd4;
        expect_req(4'd4, 4'd4);
        step();
        check("higher_req", 8'(irq_req), 8'd1);
        win_valid = 1'b0;
        step();
        check("withdraw_req", 8'(irq_req), 8'd0);
        check("withdraw_no_clear", 8'(clear_valid), 8'd0);

        // Request payload holds while the winner changes underneath.
        win_valid = 1'b1; win_id = 4'd5; win_prio = 4'd6;
        expect_req(4'd5, 4'd6);
        step();
        win_id = 4'd7; win_prio = 4'd9;
        step();
        check("hold_irq_id", 8'(irq_id), 8'd5);
        check("hold_irq_prio", 8'(irq_prio), 8'd6);
        check("hold_irq_req", 8'(irq_req), 8'd1);
        win_valid = 1'b0;
        step();
        check("withdraw2_req", 8'(irq_req), 8'd0);
        check("withdraw2_no_clear", 8'(clear_valid), 8'd0);
        win_valid = 1'b1; win_id = 4'd5; win_prio = 4'd6;
        expect_req(4'd5, 4'd6);
        step();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_req", 8'(irq_req), 8'd0);
        check("async_rst_cur", 8'(cur_prio), 8'd0);
        apply_reset();

        // Nesting 2 -> 5 -> 7, then unwind, then one return too many.
        take(4'd1, 4'd2);
        take(4'd2, 4'd5);
        take(4'd3, 4'd7);
        ret_pulse();
        check("ret1_cur", 8'(cur_prio), 8'd5);
        ret_pulse();
        check("ret2_cur", 8'(cur_prio), 8'd2);
        ret_pulse();
        check("ret3_cur", 8'(cur_prio), 8'd0);
        check("ret3_no_err", 8'(ret_err), 8'd0);
        ret_pulse();
        check("ret4_err", 8'(ret_err), 8'd1);
        check("ret4_cur", 8'(cur_prio), 8'd0);
        step();
        check("ret_err_sticky", 8'(ret_err), 8'd1);

        // Return and ack together: stack keeps {0}, level becomes the taken priority.
        apply_reset();
        take(4'd1, 4'd2);
        win_valid = 1'b1; win_id = 4'd6; win_prio = 4'd6;
        expect_req(4'd6, 4'd6);
        step();
        check("coll_req", 8'(irq_req), 8'd1);
        irq_ret = 1'b1; irq_ack = 1'b1;
        clr_q.push_back(4'd6);
        step();
        irq_ret = 1'b0; irq_ack = 1'b0; win_valid = 1'b0;
        check("coll_cur", 8'(cur_prio), 8'd6);
        ret_pulse();
        check("coll_pop_cur", 8'(cur_prio), 8'd0);
        check("coll_pop_no_err", 8'(ret_err), 8'd0);
        ret_pulse();
        check("coll_empty_err", 8'(ret_err), 8'd1);

        // Return-to-request latency: ret+1 with tail-chaining, ret+2 without.
        apply_reset();
        take(4'd1, 4'd3);
        take(4'd2, 4'd8);
        win_valid = 1'b1; win_id = 4'd9; win_prio = 4'd5;
        expect_req(4'd9, 4'd5);
        irq_ret = 1'b1;
        step();
        irq_ret = 1'b0;
        check("tail_ret1_req", 8'(irq_req), 8'(TC));
        check("tail_ret1_cur", 8'(cur_prio), 8'd3);
        step();
        check("tail_ret2_req", 8'(irq_req), 8'd1);
        irq_ack = 1'b1;
        clr_q.push_back(4'd9);
        step();
        irq_ack = 1'b0; win_valid = 1'b0;
        check("tail_ack_cur", 8'(cur_prio), 8'd5);

        // Depth-2 instance: full stack blocks requests until a return frees a slot.
        take_b(4'd1, 4'd1);
        take_b(4'd2, 4'd2);
        check("b_full", 8'(b_stack_full), 8'd1);
        b_win_valid = 1'b1; b_win_id = 4'd3; b_win_prio = 4'd9;
        step();
        step();
        check("b_full_no_req", 8'(b_irq_req), 8'd0);
        b_ret = 1'b1;
        step();
        b_ret = 1'b0;
        check("b_ret_not_full", 8'(b_stack_full), 8'd0);
        check("b_ret1_req", 8'(b_irq_req), 8'(TC));
        step();
        check("b_ret2_req", 8'(b_irq_req), 8'd1);
        check("b_req_id", 8'(b_irq_id), 8'd3);
        b_win_valid = 1'b0;
        step();
        step();

        check("req_q_drained", 8'(req_q.size()), 8'd0);
        check("clr_q_drained", 8'(clr_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_dispatch.md
Name: irq_dispatch

Overview:
- Sequential dispatch stage of the nested interrupt controller.
- Consumes the combinational arbitration winner (id, priority, valid) and raises a request to the core when the winner strictly preempts the current level.
- Runs the take/acknowledge handshake, pulses a pending-clear back to the pending bank, and tracks nesting with a saved-priority stack that is popped on interrupt return.

Parameters:
- NumIrq, 16, number of interrupt lines; IdxWidth = $clog2(NumIrq).
- PrioWidth, 4, priority width; 0 = thread level, never preempts.
- StackDepth, 8, maximum nesting depth (saved priority levels).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- win_valid  in  1  arbitration winner present (pending & enabled).
- win_id  in  IdxWidth  winner index.
- win_prio  in  PrioWidth  winner priority.
- irq_req  out  1  request to core.
- irq_id  out  IdxWidth  requested id; stable while irq_req.
- irq_prio  out  PrioWidth  requested priority; stable while irq_req.
- irq_ack  in  1  core takes the request; valid only while irq_req.
- irq_ret  in  1  single-cycle pulse: core returns from handler.
- clear_valid  out  1  one-cycle pulse: clear pending bit clear_id.
- clear_id  out  IdxWidth  id to clear.
- cur_prio  out  PrioWidth  current running level.
- stack_full  out  1  nesting stack full.
- ret_err  out  1  sticky: irq_ret seen with empty stack; cleared by reset only.

Behaviour:
- Reset values: all outputs 0, state IDLE, stack empty. Reset mid-handshake drops irq_req immediately (asynchronous) and discards the stack.
- States: IDLE, REQ.
- IDLE -> REQ when win_valid && win_prio > cur_prio (strict, unsigned) && !stack_full. Latch irq_id/irq_prio; irq_req goes high the next cycle, so latency is 1 cycle from win_valid to irq_req.
- REQ, irq_ack=1:
  - push cur_prio; cur_prio <= irq_prio; clear_valid=1 and clear_id=irq_id for one cycle; irq_req=0; go to IDLE.
  - All of this is visible at cycle ack+1. Earliest new irq_req is ack+2.
- REQ, irq_ack=0, win_valid=0: withdraw; irq_req=0 next cycle; go to IDLE.
- REQ while the winner changes to another id or priority: the request is held unchanged. No re-arbitration until the return to IDLE.
- Ack and withdraw in the same cycle: ack wins.
- irq_ret, stack non-empty: pop; cur_prio <= popped value next cycle.
- irq_ret, stack empty: ignored; ret_err <= 1.
- irq_ret and irq_ack in the same cycle (REQ): apply the pop first, then the push.
  - The pushed value is the popped value, so stack count and top are unchanged.
  - cur_prio <= irq_prio.
- irq_ret in REQ without ack: pop applies; the request stays raised (still preempting).
- Stack full: IDLE does not raise requests; irq_ret clears the full condition.
- irq_ack asserted while irq_req=0 is ignored.
- No arithmetic beyond comparison; all priorities are unsigned PrioWidth.

Optional Feature:
- Macro: IRQ_DISPATCH_TAILCHAIN_EN.
- Defined:
  - In IDLE, a cycle with irq_ret and a non-empty stack compares win_prio against the stack top (the post-pop level) instead of cur_prio.
  - A qualifying winner then raises irq_req at ret+1, the same cycle cur_prio updates.
- Undefined: the comparison always uses registered cur_prio, so the earliest irq_req after irq_ret is ret+2.

Decomposition:
- Package nclic_pkg: idx_t, prio_t, dispatch_state_e {IDLE, REQ}, and the default widths as localparams.
- Sub-module prio_stack: LIFO of prio_t, StackDepth entries.
  - Ports: push, pop, push_data, top, full, empty.
  - Simultaneous push+pop replaces the top.
  - Asynchronous active-high reset to empty.
- The irq_dispatch top holds the FSM, request latches, and clear pulse.

Test Plan:
- Basic take: after reset, win_valid=1, id=5, prio=3.
  - Required: irq_req=1, irq_id=5, irq_prio=3 at +1.
  - Ack at cycle m gives clear_valid=1, clear_id=5, cur_prio=3 at m+1.
- No preempt: with cur_prio=3, winner prio=3 -> irq_req stays 0. Winner prio=4 -> irq_req at +1.
- Nesting and return:
  - Take prio 2, then 5, then 7 -> cur_prio=7, stack {0,2,5}.
  - Three irq_ret pulses -> cur_prio 5, 2, 0; a fourth irq_ret -> ret_err=1, cur_prio stays 0.
- Full: StackDepth=2, take prio 1 and 2 -> stack_full=1; winner prio 9 gets no irq_req. One irq_ret -> irq_req rises.
- Withdraw and stability:
  - In REQ, winner changes to id 7 -> irq_id stays 5.
  - win_valid drops -> irq_req=0 next cycle, no clear_valid.
  - Async reset asserted mid-REQ -> irq_req=0 immediately.
- Ret+ack collision: stack {0}, cur_prio=2, REQ prio 6; irq_ret and irq_ack in the same cycle -> cur_prio=6, stack {0}. Also check IRQ_DISPATCH_TAILCHAIN_EN on/off ret-to-req latency (ret+1 vs ret+2).
